// File: rtl/ray_dispatcher_pkg.sv
// Shared definitions for the ray dispatcher: colours, ray field layouts and FSM state encoding.
package ray_dispatcher_pkg;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

  // init = {ox, oy, oz}, dir = {dx, dy, dz}
  localparam int OX_W   = 10;
  localparam int OY_W   = 9;
  localparam int OZ_W   = 9;
  localparam int INIT_W = OX_W + OY_W + OZ_W;
  localparam int DX_W   = 10;
  localparam int DY_W   = 10;
  localparam int DZ_W   = 11;
  localparam int DIR_W  = DX_W + DY_W + DZ_W;
  localparam int COL_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ray_dispatcher_raster_counter.sv
// Raster walker: current pixel address, look-ahead x/y for the next pixel, last-pixel flag.
module ray_dispatcher_raster_counter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x_nxt,
  output logic [Y_W-1:0]    y_nxt,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           x_wrap;
  logic           y_wrap;

  always_comb begin
    x_wrap = (x == X_W'(H_RES - 1));
    y_wrap = (y == Y_W'(V_RES - 1));
    last   = x_wrap && y_wrap;
    x_nxt  = x_wrap ? '0 : x + 1'b1;
    y_nxt  = y;
    if (x_wrap) y_nxt = y_wrap ? '0 : y + 1'b1;
  end

  // Running address replaces y*H_RES+x; it tracks x/y because both advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      x    <= x_nxt;
      y    <= y_nxt;
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: walks the raster, issues one primary ray per pixel and writes the tracer colour to the frame buffer.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int FOCAL   = 512,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [27:0]       cam_origin,
  output logic [27:0]       ray_init,
  output logic [30:0]       ray_dir,
  output logic              ray_valid,
  input  logic              tracer_ret,
  input  logic [11:0]       tracer_dout,
  input  logic              collision_sig,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       collision_cnt,
  output logic [7:0]        timeout_cnt
);

  localparam int X_W    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                ret_q;
  logic                ret_rise;
  logic                raster_clear;
  logic                raster_advance;
  logic [X_W-1:0]      x_nxt;
  logic [Y_W-1:0]      y_nxt;
  logic [ADDR_W-1:0]   pix_addr;
  logic                pix_last;

  function automatic logic [DIR_W-1:0] make_dir(input logic [X_W-1:0] px,
                                                input logic [Y_W-1:0] py);
    logic signed [DX_W-1:0] dx;
    logic signed [DY_W-1:0] dy;
    dx = DX_W'(px) - DX_W'(H_RES / 2);
    dy = DY_W'(V_RES / 2) - DY_W'(py);
    return {dx, dy, DZ_W'(FOCAL)};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign ret_rise       = tracer_ret && !ret_q;
  assign raster_clear   = (state == ST_IDLE) && start;
  assign raster_advance = (state == ST_WRITE);

  ray_dispatcher_raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (raster_clear),
    .advance (raster_advance),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt),
    .addr    (pix_addr),
    .last    (pix_last)
  );

  // Outputs are registered so each is valid during the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      ret_q         <= 1'b0;
      ray_init      <= '0;
      ray_dir       <= '0;
      ray_valid     <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      collision_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      ray_valid  <= 1'b0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ray_init      <= cam_origin;
            ray_dir       <= make_dir('0, '0);
            ray_valid     <= 1'b1;
            collision_cnt <= '0;
            timeout_cnt   <= '0;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          ret_q    <= tracer_ret;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          ret_q <= tracer_ret;
          if (ret_rise) begin
            fb_data <= tracer_dout;
            fb_we   <= 1'b1;
            fb_addr <= pix_addr;
            if (collision_sig) collision_cnt <= sat_inc16(collision_cnt);
            state   <= ST_WRITE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
            fb_data     <= BLACK;
            fb_we       <= 1'b1;
            fb_addr     <= pix_addr;
            timeout_cnt <= sat_inc8(timeout_cnt);
            state       <= ST_WRITE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          if (pix_last) begin
            frame_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            ray_dir   <= make_dir(x_nxt, y_nxt);
            ray_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
